uart_ascii_rx: RTL

Serial receive front end for the tennis scoring command path. Deserialises 8N1 UART frames from the host terminal into 7-bit ASCII characters. Each character is presented to the command decoder as a stable `data[6:0]` plus a `data_ready` strobe. The command decoder latches on the rising edge of `data_ready` and assembles sequences such as "t1\r", "s2\r" and "g\r".

---
 rtl/uart_ascii_rx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_ascii_rx.sv
// uart_ascii_rx: 8N1 UART receiver that delivers 7-bit ASCII characters to the command decoder.
// Latency: data_ready rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the start-bit edge at the pin.
// Backpressure: none; the decoder must take each one-cycle data_ready strobe as it occurs.
//
// Ports:
//   clk        - system clock; all logic runs on its rising edge
//   rst        - asynchronous active-high reset
//   rx         - asynchronous serial line, idles high
//   data       - last good character (bits [6:0] of the received byte)
//   data_ready - one-cycle strobe that marks a new valid data
//   frame_err  - one-cycle strobe for a frame with a bad (low) stop bit
//   busy       - high while a frame is in progress (START, DATA, STOP)
//
// CLKS_PER_BIT = CLK_HZ/BAUD must be at least 4, so that the half-bit count is at least 2.
module uart_ascii_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [6:0] data,
  output logic       data_ready,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  // The counter restarts at 0 on every state entry and sample, so a compare
  // against N-1 gives an N-cycle interval.
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DELIVER,
    WAIT_IDLE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shift, shift_n;
  logic [6:0]      data_n;
  logic            data_ready_n;
  logic            frame_err_n;
  logic            rx_meta;
  logic            rx_s;

  // Two-flop synchroniser. Both flops reset to the idle level so that reset
  // is never mistaken for a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data       <= '0;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      data       <= data_n;
      data_ready <= data_ready_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt + CW'(1);
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    data_n       = data;
    data_ready_n = 1'b0;
    frame_err_n  = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          bit_cnt_n = '0;
          state_n   = START;
        end
      end

      // Re-check the line at mid start bit; a short low pulse is rejected here.
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end

      // LSB first: each new bit enters at the top and walks down to bit 0.
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end

      // data is loaded here so it is already stable one cycle before the
      // registered data_ready strobe that DELIVER produces.
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift[6:0];
            state_n = DELIVER;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_IDLE;
          end
        end
      end

      DELIVER: begin
        cnt_n        = '0;
        data_ready_n = 1'b1;
        state_n      = IDLE;
      end

      // A line held low after a bad stop bit (break) must not look like a
      // fresh start bit; wait for it to return high first.
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state == START) || (state == DATA) || (state == STOP);

endmodule
